// File: rtl/sort_pkt_arbiter.sv
// Packet-level round-robin arbiter in front of a shared sort engine sink.
// Holds the grant for a whole packet, regenerates sop/eop, and caps packets at
// MAX_PKT_LEN beats by forcing eop and draining the rest of the oversize packet.
module sort_pkt_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ*DWIDTH-1:0]  snk_data_i,
  input  logic [NUM_REQ-1:0]         snk_startofpacket_i,
  input  logic [NUM_REQ-1:0]         snk_endofpacket_i,
  input  logic [NUM_REQ-1:0]         snk_valid_i,
  output logic [NUM_REQ-1:0]         snk_ready_o,
  output logic [DWIDTH-1:0]          src_data_o,
  output logic                       src_startofpacket_o,
  output logic                       src_endofpacket_o,
  output logic                       src_valid_o,
  input  logic                       src_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       trunc_o,
  output logic                       drop_o
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CW-1:0] LastBeat = CW'(MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            trunc_q, trunc_d;
  logic            drop_q, drop_d;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] orphan;
  logic               found;
  logic [GW-1:0]      win;
  logic [GW-1:0]      idx;
  logic               g_valid;
  logic               g_eop;
  logic               last_beat;
  logic               out_eop;

  assign cand      = snk_valid_i & snk_startofpacket_i;
  assign orphan    = snk_valid_i & ~snk_startofpacket_i;
  assign g_valid   = snk_valid_i[grant_q];
  assign g_eop     = snk_endofpacket_i[grant_q];
  assign last_beat = (cnt_q == LastBeat);
  assign out_eop   = g_eop | last_beat;

  // Round-robin search: first packet-start candidate strictly after the pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Data path: plain mux of the granted requester, no added latency.
  always_comb begin
    src_data_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_q) src_data_o = snk_data_i[i*DWIDTH +: DWIDTH];
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    snk_ready_o         = '0;
    src_valid_o         = 1'b0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    unique case (state_q)
      StIdle: snk_ready_o = orphan;
      StXfer: begin
        snk_ready_o[grant_q] = src_ready_i;
        src_valid_o          = g_valid;
        src_startofpacket_o  = (cnt_q == '0);
        src_endofpacket_o    = out_eop;
      end
      StDrain: snk_ready_o[grant_q] = 1'b1;
      default: ;
    endcase
    // Ready is combinational, so hold it low while reset is asserted.
    if (rst_i) snk_ready_o = '0;
  end

  // Next-state logic for arbitration, beat counting and event pulses.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop_d = |orphan;
        if (found) begin
          grant_d = win;
          ptr_d   = win;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (g_valid && src_ready_i) begin
          if (out_eop) begin
            cnt_d = '0;
            if (g_eop) begin
              state_d = StIdle;
            end else begin
              state_d = StDrain;
              trunc_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StDrain: begin
        if (g_valid && g_eop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // All state and registered pulses; reset gives req 0 first priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
      trunc_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      drop_q  <= drop_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != StIdle);
  assign trunc_o = trunc_q;
  assign drop_o  = drop_q;

endmodule
